key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Input-side conditioner for the board's 4 active-low push keys: synchronises,
//  debounces and edge-detects each raw key, and emits clean levels plus
//  one-cycle press/release events.
//  Sits between the key pins and LED/control logic, e.g. the LED-pattern
//  controller, which consumes key_stable in the same active-low 4-bit encoding.
// PARAMETERS
//  KEY_W    4          number of key channels
//  CNT_MAX  1_000_000  debounce window in sys_clk cycles (20 ms @ 50 MHz); sims use 25
//  CNT_W    $clog2(CNT_MAX)  debounce counter width (derived localparam, not overridable)
// PORTS
//  sys_clk      in   1      system clock, all logic on rising edge
//  sys_rst      in   1      synchronous, active-high reset
//  key          in   KEY_W  raw key pins, active low (0 = pressed), asynchronous
//  key_stable   out  KEY_W  debounced key level, active low
//  key_press    out  KEY_W  1-cycle pulse per channel on debounced 1->0
//  key_release  out  KEY_W  1-cycle pulse per channel on debounced 0->1
//  key_valid    out  1      1-cycle pulse, any key_press bit set this cycle
//  key_code     out  2      index of lowest-numbered key in key_press; held between events
// BEHAVIOUR
//  Reset (sys_rst=1 at an edge): sync FFs=1, all channels IDLE, counters 0,
//   key_stable=4'b1111, key_press=key_release=0, key_valid=0, key_code=0.
//  Synchroniser: 2 FFs per bit (s1<=key, s2<=s1); FSM sees s2 only.
//  Per-channel FSM (independent, identical):
//   IDLE    (stable=1): s2==0 -> FILT_DN, cnt<=0
//   FILT_DN: s2==1 -> IDLE, cnt<=0, no event (bounce rejected)
//            cnt==CNT_MAX-1 -> DOWN, stable<=0, press<=1
//            else cnt<=cnt+1
//   DOWN    (stable=0): s2==1 -> FILT_UP, cnt<=0
//   FILT_UP: s2==0 -> DOWN, cnt<=0, no event
//            cnt==CNT_MAX-1 -> IDLE, stable<=1, release<=1
//            else cnt<=cnt+1
//  press/release are registered, high exactly one cycle, else 0.
//  Latency: edge 0 = first edge sampling key low; with no bounce, stable/press
//   update at edge CNT_MAX+2. Release symmetric.
//  Any level change inside the window restarts the filter. A glitch shorter
//   than CNT_MAX cycles produces no event; stable does not move.
//  Counter saturates logically: it never exceeds CNT_MAX-1 and never wraps.
//  Simultaneous presses: all press bits pulse in the same cycle; key_valid=1;
//   key_code = lowest set index (priority encoder, registered with key_valid).
//   key_code and key_valid are valid in the same cycle as key_press.
//  Press on one channel concurrent with release on another: both pulses issued.
//  Reset mid-operation: abort the filter, go to IDLE. A key still held after
//   reset re-debounces and yields a press CNT_MAX+2 edges after reset deasserts.
//  No X propagation: all outputs driven from registers.
// STRUCTURE
//  Package key_pkg: FSM state localparams (IDLE=2'd0, FILT_DN=2'd1, DOWN=2'd2,
//   FILT_UP=2'd3), KEY_RELEASED=1'b1, default CNT_MAX.
//  Sub-module key_debounce_ch: one channel (sync FFs + FSM + counter, outputs
//   stable/press/release). Top does generate x KEY_W plus the registered
//   priority encoder for key_valid/key_code.
// TESTING  (CNT_MAX=25)
//  1 Reset held 3 cycles, key=4'b1111 -> key_stable=4'b1111, all pulses 0,
//    key_code=0.
//  2 key[0] low clean at edge 0 -> key_press=4'b0001, key_valid=1, key_code=0
//    for exactly 1 cycle after edge 27; key_stable=4'b1110 thereafter.
//  3 key[2] bounces low 10 cycles, high 3, low 10, then high -> no press, no
//    valid, key_stable stays 4'b1111.
//  4 key[1] and key[3] low on the same edge -> key_press=4'b1010, key_valid=1,
//    key_code=2'd1; release both together -> key_release=4'b1010 in one cycle.
//  5 key[0] held, sys_rst pulsed at edge 15 of FILT_DN -> no press before
//    reset; press arrives 27 edges after reset deasserts.
//  6 key[3] pressed then released clean -> key_release=4'b1000 one cycle,
//    27 edges after release; key_code keeps 2'd3 from the press.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants for the push-key conditioner: per-channel FSM encoding,
// the released (idle) pin level and the production debounce window.
package key_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILT_DN = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] FILT_UP = 2'd3;

    localparam logic KEY_RELEASED = 1'b1;

    // 20 ms at 50 MHz
    localparam int CNT_MAX_DEF = 1_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM with window counter,
// registered stable level and one-cycle press/release pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic stable,
    output logic press,
    output logic rel,
    output logic press_next
);

    localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stable_nxt;
    logic             rel_nxt;

    // The counter only advances while the window is open and is cleared on
    // every state change, so it never passes CNT_LAST and cannot wrap.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        press_next = 1'b0;
        rel_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (s2 != KEY_RELEASED) begin
                    state_nxt = FILT_DN;
                    cnt_nxt   = '0;
                end
            end
            FILT_DN: begin
                if (s2 == KEY_RELEASED) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = DOWN;
                    cnt_nxt    = '0;
                    stable_nxt = ~KEY_RELEASED;
                    press_next = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (s2 == KEY_RELEASED) begin
                    state_nxt = FILT_UP;
                    cnt_nxt   = '0;
                end
            end
            FILT_UP: begin
                if (s2 != KEY_RELEASED) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    stable_nxt = KEY_RELEASED;
                    rel_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1     <= KEY_RELEASED;
            s2     <= KEY_RELEASED;
            state  <= IDLE;
            cnt    <= '0;
            stable <= KEY_RELEASED;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            s1     <= key;
            s2     <= s1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
            press  <= press_next;
            rel    <= rel_nxt;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Conditioner for the active-low push keys: one debounce channel per key plus
// a registered priority encoder reporting the lowest key pressed this cycle.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W   = 4,
    parameter int CNT_MAX = CNT_MAX_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_stable,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_valid,
    output logic [1:0]       key_code
);

    logic [KEY_W-1:0] press_next;
    logic [1:0]       code_nxt;

    for (genvar i = 0; i < KEY_W; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX (CNT_MAX)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .key        (key[i]),
            .stable     (key_stable[i]),
            .press      (key_press[i]),
            .rel        (key_release[i]),
            .press_next (press_next[i])
        );
    end

    // Encoding the channels' next-press terms lets valid/code register on the
    // same edge as key_press, so all three are seen together.
    always_comb begin
        code_nxt = key_code;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (press_next[i]) begin
                code_nxt = 2'(i);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_valid <= 1'b0;
            key_code  <= 2'd0;
        end else begin
            key_valid <= |press_next;
            key_code  <= code_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (CNT_MAX=25): directed scenarios plus
// random bouncing keys, all compared against a run-length reference model.
module tb_key_debounce;

    localparam int KEY_W   = 4;
    localparam int CNT_MAX = 25;
    localparam int LAT     = CNT_MAX + 2;

    logic             sys_clk;
    logic             sys_rst;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic             key_valid;
    logic [1:0]       key_code;

    int checks = 0;
    int errors = 0;

    // Reference model: a level flips once it has disagreed with the pin
    // (as seen two flops late) for CNT_MAX+1 consecutive edges.
    logic [3:0] m_s1, m_s2, m_stable, m_press, m_rel;
    logic       m_valid;
    logic [1:0] m_code;
    int         run [4];

    key_debounce #(
        .KEY_W   (KEY_W),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .key_stable  (key_stable),
        .key_press   (key_press),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_code    (key_code)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] k, input logic r);
        logic [3:0] seen;
        bit         found;
        if (r) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
            m_press = 4'h0; m_rel = 4'h0; m_valid = 1'b0; m_code = 2'd0;
            for (int c = 0; c < 4; c++) run[c] = 0;
        end else begin
            seen    = m_s2;
            m_s2    = m_s1;
            m_s1    = k;
            m_press = 4'h0;
            m_rel   = 4'h0;
            for (int c = 0; c < 4; c++) begin
                if (seen[c] != m_stable[c]) begin
                    run[c]++;
                    if (run[c] == CNT_MAX + 1) begin
                        m_stable[c] = seen[c];
                        if (seen[c] == 1'b0) m_press[c] = 1'b1;
                        else                 m_rel[c]   = 1'b1;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            m_valid = (m_press != 4'h0);
            found   = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (!found && m_press[c]) begin
                    m_code = 2'(c);
                    found  = 1'b1;
                end
            end
        end
    endtask

    // One clock edge: drive, advance the model, then compare away from the edge.
    task automatic step(input logic [3:0] k, input logic r);
        key     = k;
        sys_rst = r;
        @(posedge sys_clk);
        model_edge(k, r);
        #1;
        chk("model_stable",  key_stable,  m_stable);
        chk("model_press",   key_press,   m_press);
        chk("model_release", key_release, m_rel);
        chk("model_valid",   {3'b0, key_valid}, {3'b0, m_valid});
        chk("model_code",    {2'b0, key_code},  {2'b0, m_code});
    endtask

    logic [3:0] lvl;
    int         left [4];
    logic [3:0] pat;

    initial begin
        key     = 4'hF;
        sys_rst = 1'b1;

        // Reset state
        repeat (3) step(4'hF, 1'b1);
        chk("rst_stable", key_stable, 4'hF);
        chk("rst_press", key_press, 4'h0);
        chk("rst_release", key_release, 4'h0);
        chk("rst_valid", {3'b0, key_valid}, 4'h0);
        chk("rst_code", {2'b0, key_code}, 4'h0);
        repeat (3) step(4'hF, 1'b0);

        // Clean press on key 0: pulse on edge 27 only
        for (int e = 0; e <= LAT; e++) begin
            step(4'b1110, 1'b0);
            if (e == LAT) begin
                chk("k0_press", key_press, 4'b0001);
                chk("k0_valid", {3'b0, key_valid}, 4'h1);
                chk("k0_code", {2'b0, key_code}, 4'h0);
                chk("k0_stable", key_stable, 4'b1110);
            end else begin
                chk("k0_early_press", key_press, 4'h0);
                chk("k0_early_stable", key_stable, 4'hF);
            end
        end
        step(4'b1110, 1'b0);
        chk("k0_press_1cyc", key_press, 4'h0);
        chk("k0_valid_1cyc", {3'b0, key_valid}, 4'h0);
        chk("k0_stable_held", key_stable, 4'b1110);
        for (int e = 0; e <= LAT; e++) begin
            step(4'hF, 1'b0);
            if (e == LAT) chk("k0_release", key_release, 4'b0001);
        end
        repeat (4) step(4'hF, 1'b0);

        // Bouncing key 2: low 10, high 3, low 10, then high
        for (int e = 0; e < 60; e++) begin
            pat = ((e < 10) || (e >= 13 && e < 23)) ? 4'b1011 : 4'hF;
            step(pat, 1'b0);
            chk("bounce_stable", key_stable, 4'hF);
            chk("bounce_press", key_press, 4'h0);
            chk("bounce_valid", {3'b0, key_valid}, 4'h0);
        end

        // Keys 1 and 3 together
        for (int e = 0; e <= LAT; e++) begin
            step(4'b0101, 1'b0);
            if (e == LAT) begin
                chk("k13_press", key_press, 4'b1010);
                chk("k13_valid", {3'b0, key_valid}, 4'h1);
                chk("k13_code", {2'b0, key_code}, 4'h1);
            end
        end
        for (int e = 0; e <= LAT; e++) begin
            step(4'hF, 1'b0);
            if (e == LAT) chk("k13_release", key_release, 4'b1010);
            else          chk("k13_no_early_release", key_release, 4'h0);
        end
        repeat (4) step(4'hF, 1'b0);

        // Reset mid-filter on key 0, key still held
        for (int e = 0; e < 17; e++) begin
            step(4'b1110, 1'b0);
            chk("midrst_no_press", key_press, 4'h0);
        end
        step(4'b1110, 1'b1);
        chk("midrst_stable", key_stable, 4'hF);
        // e=0 is the first edge with reset low
        for (int e = 0; e <= LAT; e++) begin
            step(4'b1110, 1'b0);
            if (e == LAT) chk("midrst_press", key_press, 4'b0001);
            else          chk("midrst_early", key_press, 4'h0);
        end
        for (int e = 0; e <= LAT + 3; e++) step(4'hF, 1'b0);

        // Key 3 press then release; code holds 3
        for (int e = 0; e <= LAT; e++) begin
            step(4'b0111, 1'b0);
            if (e == LAT) begin
                chk("k3_press", key_press, 4'b1000);
                chk("k3_code", {2'b0, key_code}, 4'h3);
            end
        end
        for (int e = 0; e <= LAT; e++) begin
            step(4'hF, 1'b0);
            if (e == LAT) begin
                chk("k3_release", key_release, 4'b1000);
                chk("k3_code_held", {2'b0, key_code}, 4'h3);
                chk("k3_stable", key_stable, 4'hF);
            end
        end

        // Random bouncing keys with occasional reset
        lvl = 4'hF;
        for (int c = 0; c < 4; c++) left[c] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    lvl[c]  = ~lvl[c];
                    left[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 28))
                                                         : int'($urandom_range(28, 70));
                end
            end
            step(lvl, ($urandom_range(0, 599) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
